// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable data memory with RISC-V load/store
// semantics. Requests use a valid/ready handshake and results are held in a
// single response register that supports back-pressure from the consumer.
module data_memory_lsu #(
  parameter int unsigned MEM_SIZE_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE_WORDS);
  // Byte size of the array; 33 bits so the largest legal depth still fits.
  localparam logic [32:0] MEM_BYTES = 33'(MEM_SIZE_WORDS) << 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  rsp_state_t state;

  logic [31:0]           mem [MEM_SIZE_WORDS];
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           mem_word;
  logic                  accept;
  logic                  range_fault;
  logic                  misalign_fault;
  logic                  encoding_fault;
  logic                  fault;
  logic                  mem_we;
  logic [3:0]            byte_en;
  logic [31:0]           store_data;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_value;
  logic [31:0]           rdata_next;

  assign off      = req_addr - BASE_ADDR;
  assign word_idx = off[ADDR_WIDTH+1:2];
  assign lane     = off[1:0];
  assign mem_word = mem[word_idx];

  assign rsp_valid = (state == FULL);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign fault     = range_fault || misalign_fault || encoding_fault;
  assign mem_we    = accept && rst_n && req_write && !fault;

  // Classify the request: out of range, misaligned for its size, or an
  // funct3 that has no meaning for the requested direction.
  always_comb begin
    range_fault = ({1'b0, off} >= MEM_BYTES);
    case (req_funct3[1:0])
      2'b01:   misalign_fault = off[0];
      2'b10:   misalign_fault = (off[1:0] != 2'b00);
      default: misalign_fault = 1'b0;
    endcase
    if (req_write) begin
      encoding_fault = (req_funct3 > 3'd2);
    end else begin
      case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: encoding_fault = 1'b0;
        default:                      encoding_fault = 1'b1;
      endcase
    end
  end

  // Replicate store data across lanes and pick the byte enables, so the
  // array write itself is a plain per-lane masked update.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = req_wdata;
    case (req_funct3)
      3'd0: begin
        store_data = {4{req_wdata[7:0]}};
        byte_en    = 4'b0001 << lane;
      end
      3'd1: begin
        store_data = {2{req_wdata[15:0]}};
        byte_en    = off[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        byte_en = 4'b1111;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

  // Pull the addressed byte/halfword out of the word and extend it.
  always_comb begin
    case (lane)
      2'd0:    load_byte = mem_word[7:0];
      2'd1:    load_byte = mem_word[15:8];
      2'd2:    load_byte = mem_word[23:16];
      default: load_byte = mem_word[31:24];
    endcase
    load_half = off[1] ? mem_word[31:16] : mem_word[15:0];
    case (req_funct3)
      3'd0:    load_value = {{24{load_byte[7]}}, load_byte};
      3'd1:    load_value = {{16{load_half[15]}}, load_half};
      3'd2:    load_value = mem_word;
      3'd4:    load_value = {24'h000000, load_byte};
      3'd5:    load_value = {16'h0000, load_half};
      default: load_value = 32'h0000_0000;
    endcase
    rdata_next = (fault || req_write) ? 32'h0000_0000 : load_value;
  end

  // Array write: unselected lanes keep their contents; the array is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  // Response register: captures every accepted request and drains on rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      rsp_rdata <= 32'h0000_0000;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            rsp_rdata <= rdata_next;
            rsp_fault <= fault;
          end
        end
        FULL: begin
          if (accept) begin
            rsp_rdata <= rdata_next;
            rsp_fault <= fault;
          end else if (rsp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed and randomized checks of data_memory_lsu
// against a byte-array model of little-endian RISC-V load/store behaviour.
module tb_data_memory_lsu;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

  typedef struct packed {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int   total;
  int   passed;
  int   accept_count;
  logic [7:0] mdl [MEM_BYTES];
  req_t stream_q [$];

  data_memory_lsu #(.MEM_SIZE_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes as the DUT sees them.
  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) accept_count++;
  end

  // Reference model: bytes addressed by offset, little-endian, applied in order.
  task automatic model_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    logic [31:0] off;
    int n;
    logic [31:0] v;
    off = a - BASE;
    n = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    flt = (off >= MEM_BYTES) || ((off % n) != 0);
    if (w) flt = flt || (f3 > 3'd2);
    else   flt = flt || !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    rd = 32'h0;
    if (!flt) begin
      if (w) begin
        for (int b = 0; b < n; b++) mdl[off + b] = wd[8*b +: 8];
      end else begin
        v = 32'h0;
        for (int b = 0; b < n; b++) v = v | (32'(mdl[off + b]) << (8*b));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  // Single request with rsp_ready=1; returns the response half a cycle after accept.
  task automatic transact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic v, output logic [31:0] d,
                          output logic f);
    logic [31:0] md;
    logic mf;
    int n;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    model_access(w, f3, a, wd, md, mf);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      total++;
      $display("[TB] FAIL transact_ready_timeout: req_ready=%b, want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    v = rsp_valid; d = rsp_rdata; f = rsp_fault;
  endtask

  // Stream stream_q back-to-back and check each response in order against the model.
  task automatic run_stream(input string tag);
    logic [31:0] exp_d [$];
    logic        exp_f [$];
    logic [31:0] md;
    logic        mf;
    int n;
    int start_cnt;
    n = stream_q.size();
    rsp_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i == 0) start_cnt = accept_count;
      if (i > 0) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d[i-1] || rsp_fault !== exp_f[i-1])
          $display("[TB] FAIL %s[%0d]: got v=%b d=%h f=%b, want v=1 d=%h f=%b",
                   tag, i-1, rsp_valid, rsp_rdata, rsp_fault, exp_d[i-1], exp_f[i-1]);
        else passed++;
      end
      if (i < n) begin
        req_valid = 1'b1; req_write = stream_q[i].w; req_funct3 = stream_q[i].f3;
        req_addr = stream_q[i].a; req_wdata = stream_q[i].wd;
        model_access(stream_q[i].w, stream_q[i].f3, stream_q[i].a, stream_q[i].wd, md, mf);
        exp_d.push_back(md);
        exp_f.push_back(mf);
      end else begin
        req_valid = 1'b0;
      end
    end
    total++;
    if (accept_count - start_cnt !== n)
      $display("[TB] FAIL %s_accepts: got %0d, want %0d", tag, accept_count - start_cnt, n);
    else passed++;
    stream_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_fault !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL reset_values: got v=%b d=%h f=%b rdy=%b, want 0/0/0/1",
               rsp_valid, rsp_rdata, rsp_fault, req_ready);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL post_reset_idle: got v=%b rdy=%b, want v=0 rdy=1", rsp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_word_roundtrip;
    logic v, f;
    logic [31:0] d;
    transact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, v, d, f);
    total++;
    if (v !== 1'b1 || d !== 32'h0 || f !== 1'b0)
      $display("[TB] FAIL sw_response: got v=%b d=%h f=%b, want v=1 d=0 f=0", v, d, f);
    else passed++;
    transact(1'b0, 3'd2, 32'h10, 32'h0, v, d, f);
    total++;
    if (v !== 1'b1 || d !== 32'hDEADBEEF || f !== 1'b0)
      $display("[TB] FAIL lw_roundtrip: got v=%b d=%h f=%b, want v=1 d=deadbeef f=0", v, d, f);
    else passed++;
  endtask

  task automatic test_byte_lanes;
    logic v, f;
    logic [31:0] d;
    logic [2:0]  lf3 [5] = '{3'd2, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] la  [5] = '{32'h20, 32'h21, 32'h21, 32'h22, 32'h22};
    logic [31:0] le  [5] = '{32'hBEEFAA44, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFFBEEF, 32'h0000BEEF};
    transact(1'b1, 3'd2, 32'h20, 32'h11223344, v, d, f);
    transact(1'b1, 3'd0, 32'h21, 32'h000000AA, v, d, f);
    transact(1'b1, 3'd1, 32'h22, 32'h0000BEEF, v, d, f);
    for (int i = 0; i < 5; i++) begin
      transact(1'b0, lf3[i], la[i], 32'h0, v, d, f);
      total++;
      if (v !== 1'b1 || d !== le[i] || f !== 1'b0)
        $display("[TB] FAIL byte_lane_load[%0d]: got v=%b d=%h f=%b, want v=1 d=%h f=0",
                 i, v, d, f, le[i]);
      else passed++;
    end
  endtask

  task automatic test_faults;
    logic v, f;
    logic [31:0] d;
    logic        fw  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  ff3 [6] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
    logic [31:0] fa  [6] = '{32'h22, 32'h23, MEM_BYTES, 32'h20, 32'h20, 32'hFFFF_FFFC};
    for (int i = 0; i < 6; i++) begin
      transact(fw[i], ff3[i], fa[i], 32'hFFFF_FFFF, v, d, f);
      total++;
      if (v !== 1'b1 || d !== 32'h0 || f !== 1'b1)
        $display("[TB] FAIL fault_case[%0d]: got v=%b d=%h f=%b, want v=1 d=0 f=1", i, v, d, f);
      else passed++;
      transact(1'b0, 3'd2, 32'h20, 32'h0, v, d, f);
      total++;
      if (v !== 1'b1 || d !== 32'hBEEFAA44 || f !== 1'b0)
        $display("[TB] FAIL fault_no_effect[%0d]: got d=%h f=%b, want d=beefaa44 f=0", i, d, f);
      else passed++;
    end
  endtask

  task automatic test_back_pressure;
    int base_cnt;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_addr = 32'h10;
    base_cnt = accept_count;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEFAA44 || rsp_fault !== 1'b0)
      $display("[TB] FAIL bp_first_rsp: got v=%b d=%h f=%b, want v=1 d=beefaa44 f=0",
               rsp_valid, rsp_rdata, rsp_fault);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEFAA44 ||
          rsp_fault !== 1'b0 || accept_count !== base_cnt)
        $display("[TB] FAIL bp_stall[%0d]: got rdy=%b v=%b d=%h f=%b acc=%0d, want 0/1/beefaa44/0/%0d",
                 k, req_ready, rsp_valid, rsp_rdata, rsp_fault, accept_count, base_cnt);
      else passed++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (accept_count !== base_cnt + 1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      $display("[TB] FAIL bp_release: got acc=%0d v=%b d=%h, want acc=%0d v=1 d=deadbeef",
               accept_count, rsp_valid, rsp_rdata, base_cnt + 1);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || accept_count !== base_cnt + 1)
      $display("[TB] FAIL bp_drain: got v=%b acc=%0d, want v=0 acc=%0d",
               rsp_valid, accept_count, base_cnt + 1);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic v, f;
    logic [31:0] d;
    for (int i = 0; i < 8; i++)
      transact(1'b1, 3'd2, 32'h80 + 32'(4*i), $urandom, v, d, f);
    stream_q.push_back('{w: 1'b1, f3: 3'd2, a: 32'h40, wd: $urandom});
    stream_q.push_back('{w: 1'b0, f3: 3'd2, a: 32'h40, wd: 32'h0});
    for (int i = 0; i < 8; i++)
      stream_q.push_back('{w: 1'b0, f3: 3'd2, a: 32'h80 + 32'(4*i), wd: 32'h0});
    run_stream("b2b");
  endtask

  task automatic test_random;
    int r;
    logic [31:0] a;
    for (int i = 0; i < 64; i++)
      stream_q.push_back('{w: 1'b1, f3: 3'd2, a: 32'h100 + 32'(4*i), wd: $urandom});
    run_stream("rand_init");
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'h100 + 32'($urandom_range(0, 255));
      else if (r == 8) a = MEM_BYTES + 32'($urandom_range(0, 255));
      else             a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      stream_q.push_back('{w: 1'($urandom_range(0, 1)), f3: 3'($urandom_range(0, 7)),
                           a: a, wd: $urandom});
    end
    run_stream("rand");
  endtask

  task automatic test_reset_during_op;
    logic v, f;
    logic [31:0] d;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      $display("[TB] FAIL rst_op_pending: got v=%b d=%h, want v=1 d=deadbeef", rsp_valid, rsp_rdata);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_fault !== 1'b0)
      $display("[TB] FAIL rst_op_async_clear: got v=%b d=%h f=%b, want 0/0/0",
               rsp_valid, rsp_rdata, rsp_fault);
    else passed++;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10;
    req_wdata = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    transact(1'b0, 3'd2, 32'h10, 32'h0, v, d, f);
    total++;
    if (v !== 1'b1 || d !== 32'hDEADBEEF || f !== 1'b0)
      $display("[TB] FAIL rst_op_data_kept_10: got v=%b d=%h f=%b, want v=1 d=deadbeef f=0", v, d, f);
    else passed++;
    transact(1'b0, 3'd2, 32'h20, 32'h0, v, d, f);
    total++;
    if (v !== 1'b1 || d !== 32'hBEEFAA44 || f !== 1'b0)
      $display("[TB] FAIL rst_op_data_kept_20: got v=%b d=%h f=%b, want v=1 d=beefaa44 f=0", v, d, f);
    else passed++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    total = 0; passed = 0; accept_count = 0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    test_reset();
    test_word_roundtrip();
    test_byte_lanes();
    test_faults();
    test_back_pressure();
    test_back_to_back();
    test_random();
    test_reset_during_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
